// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package sub_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage : sub_pkg

// File: rtl/full_sub.sv
// Single-bit full subtractor cell: diff = a - b - bi, bo = borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = a ^ b ^ bi;
    assign bo   = (~a & (b | bi)) | (b & bi);

endmodule : full_sub

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full_sub cell stepped LSB first,
// one bit per clock, returning a - b - bin and the final borrow.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             brw_q,    brw_d;
    logic             bout_q,   bout_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic cell_diff_s;
    logic cell_bo_s;
    logic last_bit_s;

    full_sub u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bi   (brw_q),
        .diff (cell_diff_s),
        .bo   (cell_bo_s)
    );

    assign last_bit_s = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            ST_RUN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign diff = diff_q;
    assign bout = bout_q;

    // Datapath next values: operand capture, shifting and result commit
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    brw_d    = bin;
                    cnt_d    = {CW{1'b0}};
                    res_sh_d = {WIDTH{1'b0}};
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {cell_diff_s, res_sh_q[WIDTH-1:1]};
                brw_d    = cell_bo_s;
                // Counter parks on the last index so it never wraps
                if (last_bit_s) begin
                    cnt_d  = cnt_q;
                    diff_d = {cell_diff_s, res_sh_q[WIDTH-1:1]};
                    bout_d = cell_bo_s;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            brw_q    <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            brw_q    <= brw_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule : serial_subtractor
